// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and constants for the FIFO-to-AXI4-Stream drain engine.
//   occ_e   - occupancy state of the 2-entry output buffer (the encoding doubles as a word count)
//   STATS_W - width of the optional packet/stall statistics counters
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: 2-entry output buffer that hides the FIFO's 1-cycle read latency.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   wr, wr_data - write of one word into the tail
//   pop         - remove the head word (AXIS handshake)
//   head, valid - head word and non-empty flag
//   occ         - occupancy state (EMPTY/ONE/TWO)
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int unsigned BITLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [BITLEN-1:0] wr_data,
  input  logic              pop,
  output logic [BITLEN-1:0] head,
  output logic              valid,
  output occ_e              occ
);

  logic [BITLEN-1:0] head_q;
  logic [BITLEN-1:0] tail_q;
  occ_e              occ_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (wr) begin
            head_q <= wr_data;
            occ_q  <= ONE;
          end
        end
        ONE: begin
          if (wr && pop) begin
            head_q <= wr_data;
          end else if (wr) begin
            tail_q <= wr_data;
            occ_q  <= TWO;
          end else if (pop) begin
            occ_q <= EMPTY;
          end
        end
        TWO: begin
          // The credit logic in the top never lets a write land here without a pop.
          if (pop) begin
            head_q <= tail_q;
            if (wr) begin
              tail_q <= wr_data;
            end else begin
              occ_q <= ONE;
            end
          end
        end
        default: occ_q <= EMPTY;
      endcase
    end
  end

  assign head  = head_q;
  assign valid = (occ_q != EMPTY);
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: pops words from a synchronous FIFO (1-cycle read latency) and presents
// them as an AXI4-Stream master, with tlast every PKT_LEN beats and 1 beat/cycle sustained.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   en                    - allow new FIFO reads (buffered/in-flight words always drain)
//   fifo_empty, fifo_rd_en, fifo_dout - FIFO read interface
//   m_tvalid, m_tready, m_tdata, m_tkeep, m_tlast - AXIS master
//   busy                  - a word is buffered or in flight
//   pkt_cnt, stall_cnt    - only with FIFO_AXIS_DRAIN_STATS_EN defined: packets sent and
//                           cycles stalled by the sink
module fifo_axis_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned BITLEN  = 64,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [BITLEN-1:0]   fifo_dout,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [BITLEN-1:0]   m_tdata,
  output logic [BITLEN/8-1:0] m_tkeep,
  output logic                m_tlast,
`ifdef FIFO_AXIS_DRAIN_STATS_EN
  output logic [STATS_W-1:0]  pkt_cnt,
  output logic [STATS_W-1:0]  stall_cnt,
`endif
  output logic                busy
);

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(PKT_LEN - 1);

  logic             hs;
  logic             inflight_q;
  occ_e             occ;
  logic [1:0]       occ_cnt;
  logic [1:0]       level;
  logic [CNT_W-1:0] beat_q;

  assign hs = m_tvalid & m_tready;

  // Words that will still be held after this cycle's handshake; a new pop is allowed only
  // if that leaves room for it in the 2-entry buffer. Reset gates it so no word is lost.
  assign occ_cnt    = occ;
  assign level      = occ_cnt + {1'b0, inflight_q} - {1'b0, hs};
  assign fifo_rd_en = rst_n & en & ~fifo_empty & (level <= 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
    end
  end

  fifo_drain_skid #(
    .BITLEN (BITLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (inflight_q),
    .wr_data (fifo_dout),
    .pop     (hs),
    .head    (m_tdata),
    .valid   (m_tvalid),
    .occ     (occ)
  );

  // Beat position within the packet; held across en gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (hs) begin
      beat_q <= (beat_q == LastBeat) ? '0 : beat_q + CNT_W'(1);
    end
  end

  assign m_tlast = m_tvalid & (beat_q == LastBeat);
  assign m_tkeep = '1;
  assign busy    = (occ != EMPTY) | inflight_q;

`ifdef FIFO_AXIS_DRAIN_STATS_EN
  logic [STATS_W-1:0] pkt_cnt_q;
  logic [STATS_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs && m_tlast) begin
        pkt_cnt_q <= pkt_cnt_q + STATS_W'(1);
      end
      if (m_tvalid && !m_tready) begin
        stall_cnt_q <= stall_cnt_q + STATS_W'(1);
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Directed bench for fifo_axis_drain: a PKT_LEN=16 instance for the main scenarios and a
// PKT_LEN=4 instance for short packets (and the statistics counters when enabled).
`timescale 1ns/1ps
module tb_fifo_axis_drain;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, ready, fclr;
  logic fifo_empty, fifo_rd_en, m_tvalid, m_tlast, busy;
  logic [W-1:0] fifo_dout, m_tdata;
  logic [W/8-1:0] m_tkeep;
  logic f4_empty, f4_rd_en, v4, l4, busy4;
  logic [W-1:0] f4_dout, d4;
  logic [W/8-1:0] k4;
`ifdef FIFO_AXIS_DRAIN_STATS_EN
  logic [31:0] pkt_cnt, stall_cnt, pkt4, stall4;
`endif

  fifo_axis_drain #(.BITLEN(W), .PKT_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .m_tvalid(m_tvalid), .m_tready(ready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  fifo_axis_drain #(.BITLEN(W), .PKT_LEN(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(f4_empty), .fifo_rd_en(f4_rd_en),
    .fifo_dout(f4_dout), .m_tvalid(v4), .m_tready(ready), .m_tdata(d4),
    .m_tkeep(k4), .m_tlast(l4),
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    .pkt_cnt(pkt4), .stall_cnt(stall4),
`endif
    .busy(busy4)
  );

  // FIFO models: word i holds value i, registered read data.
  logic [5:0] wr_ptr, rd_ptr, wr4, rd4;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign f4_empty   = (rd4 == wr4);

  always @(posedge clk) begin
    if (fclr) begin
      rd_ptr <= '0;
      fifo_dout <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= W'(rd_ptr);
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always @(posedge clk) begin
    if (fclr) begin
      rd4 <= '0;
      f4_dout <= '0;
    end else if (f4_rd_en && !f4_empty) begin
      f4_dout <= W'(rd4);
      rd4 <= rd4 + 6'd1;
    end
  end

  // Monitor: logs handshakes and counts protocol violations.
  int cyc = 0;
  int npops, first_rd, first_v, outst, v_empty_rd, v_stable, v_ovf, st4;
  logic [W-1:0] bdata[$];
  logic blast[$];
  int bcyc[$];
  logic [W-1:0] b4data[$];
  logic b4last[$];
  logic pstall, plast;
  logic [W-1:0] pdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fclr) begin
      npops <= 0; first_rd <= -1; first_v <= -1; outst <= 0;
      v_empty_rd <= 0; v_stable <= 0; v_ovf <= 0; st4 <= 0; pstall <= 1'b0;
      bdata.delete(); blast.delete(); bcyc.delete(); b4data.delete(); b4last.delete();
    end else begin
      if ((fifo_rd_en && fifo_empty) || (f4_rd_en && f4_empty)) v_empty_rd <= v_empty_rd + 1;
      if (fifo_rd_en) npops <= npops + 1;
      if (fifo_rd_en && first_rd < 0) first_rd <= cyc;
      if (m_tvalid && first_v < 0) first_v <= cyc;
      if (outst > 2) v_ovf <= v_ovf + 1;
      outst <= !rst_n ? 0 : outst + int'(fifo_rd_en) - int'(m_tvalid && ready);
      if (pstall && (!m_tvalid || m_tdata !== pdata || m_tlast !== plast))
        v_stable <= v_stable + 1;
      pstall <= rst_n && m_tvalid && !ready;
      pdata <= m_tdata;
      plast <= m_tlast;
      if (rst_n && m_tvalid && ready) begin
        bdata.push_back(m_tdata); blast.push_back(m_tlast); bcyc.push_back(cyc);
      end
      if (rst_n && v4 && ready) begin
        b4data.push_back(d4); b4last.push_back(l4);
      end
      if (rst_n && v4 && !ready) st4 <= st4 + 1;
    end
  end

  int checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reset both DUTs and reload both FIFO models with n and n4 words.
  task automatic setup(input int n, input int n4, input bit chk_rst);
    rst_n = 1'b0; en = 1'b1; ready = 1'b0; fclr = 1'b1;
    wr_ptr = 6'(n); wr4 = 6'(n4);
    tick(); tick();
    if (chk_rst) begin
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en_gated", fifo_rd_en, 0);
    end
    en = 1'b0; fclr = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_beats(input bit sel4, input int n, input int budget, input string tag);
    int k = 0;
    while (((sel4 ? b4data.size() : bdata.size()) < n) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, sel4 ? b4data.size() : bdata.size(), n);
  endtask

  // Mismatches of beats [from, from+n) against consecutive words starting at first_word.
  function automatic int bad_order(input bit sel4, input int from, input int first_word,
                                   input int n);
    int bad = 0;
    for (int i = from; i < from + n; i++) begin
      if (sel4) begin
        if (i >= b4data.size() || b4data[i] !== W'(first_word + i - from)) bad++;
      end else begin
        if (i >= bdata.size() || bdata[i] !== W'(first_word + i - from)) bad++;
      end
    end
    return bad;
  endfunction

  // Mismatches of tlast over beats [from, from+n) against a last-of-every-period pattern.
  function automatic int bad_last(input bit sel4, input int from, input int n, input int period);
    int bad = 0;
    for (int i = from; i < from + n; i++) begin
      logic exp_l = (((i - from) % period) == period - 1);
      if (sel4) begin
        if (i >= b4last.size() || b4last[i] !== exp_l) bad++;
      end else begin
        if (i >= blast.size() || blast[i] !== exp_l) bad++;
      end
    end
    return bad;
  endfunction

  function automatic int max_gap();
    int g = 0;
    for (int i = 1; i < bcyc.size(); i++) if (bcyc[i] - bcyc[i-1] > g) g = bcyc[i] - bcyc[i-1];
    return g;
  endfunction

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; fclr = 1'b1; wr_ptr = '0; wr4 = '0;

    // 1: full-rate drain of 32 words
    setup(32, 0, 1'b1);
    en = 1'b1; ready = 1'b1;
    wait_beats(1'b0, 32, 200, "s1_beats");
    tick(); tick();
    chk("s1_order", bad_order(1'b0, 0, 0, 32), 0);
    chk("s1_tlast_15", blast[15], 1);
    chk("s1_tlast_31", blast[31], 1);
    chk("s1_tlast_pattern", bad_last(1'b0, 0, 32, 16), 0);
    chk("s1_rate", bcyc[31] - bcyc[0], 31);
    chk("s1_latency", first_v - first_rd, 2);
    chk("s1_idle_busy", busy, 0);
    chk("s1_tkeep", m_tkeep, 8'hFF);

    // 2: alternating tready
    setup(32, 0, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 400 && bdata.size() < 32; k++) begin
      ready = ~ready;
      tick();
    end
    chk("s2_beats", bdata.size(), 32);
    chk("s2_order", bad_order(1'b0, 0, 0, 32), 0);
    chk("s2_tlast_pattern", bad_last(1'b0, 0, 32, 16), 0);
    chk("s2_stall_stable", v_stable, 0);
    chk("s2_rd_while_empty", v_empty_rd, 0);
    chk("s2_overflow", v_ovf, 0);

    // 3: long backpressure then release
    setup(32, 0, 1'b0);
    en = 1'b1; ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("s3_pops_stalled", npops, 2);
    chk("s3_rd_en_stalled", fifo_rd_en, 0);
    chk("s3_tvalid_stalled", m_tvalid, 1);
    chk("s3_tdata_stalled", m_tdata, 0);
    ready = 1'b1;
    wait_beats(1'b0, 32, 200, "s3_beats");
    chk("s3_order", bad_order(1'b0, 0, 0, 32), 0);
    chk("s3_gap_ok", max_gap() <= 2, 1);
    chk("s3_overflow", v_ovf, 0);

    // 4: en gap after beat 5
    setup(32, 0, 1'b0);
    en = 1'b1; ready = 1'b1;
    wait_beats(1'b0, 6, 100, "s4_pre_gap");
    en = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("s4_gap_beats", bdata.size(), 8);
    chk("s4_gap_busy", busy, 0);
    chk("s4_gap_tvalid", m_tvalid, 0);
    en = 1'b1;
    wait_beats(1'b0, 32, 200, "s4_beats");
    chk("s4_order", bad_order(1'b0, 0, 0, 32), 0);
    chk("s4_tlast_pattern", bad_last(1'b0, 0, 32, 16), 0);

    // 5: reset mid-packet with the buffer full
    setup(32, 0, 1'b0);
    en = 1'b1; ready = 1'b1;
    wait_beats(1'b0, 7, 100, "s5_pre_rst");
    ready = 1'b0;
    tick(); tick(); tick();
    chk("s5_head_before_rst", m_tdata, 7);
    chk("s5_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("s5_rst_tvalid", m_tvalid, 0);
    chk("s5_rst_tdata", m_tdata, 0);
    chk("s5_rst_tlast", m_tlast, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1; ready = 1'b1;
    wait_beats(1'b0, 23, 200, "s5_beats");
    chk("s5_order_pre", bad_order(1'b0, 0, 0, 7), 0);
    chk("s5_order_post", bad_order(1'b0, 7, 9, 16), 0);
    chk("s5_tlast_post", bad_last(1'b0, 7, 16, 16), 0);

    // 6: PKT_LEN=4 instance, 3 packets with 5 stall cycles
    setup(0, 12, 1'b0);
    en = 1'b1; ready = 1'b1;
    wait_beats(1'b1, 2, 100, "s6_pre_stall");
    ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    ready = 1'b1;
    wait_beats(1'b1, 12, 100, "s6_beats");
    tick(); tick(); tick();
    chk("s6_order", bad_order(1'b1, 0, 0, 12), 0);
    chk("s6_tlast_pattern", bad_last(1'b1, 0, 12, 4), 0);
    chk("s6_bench_stalls", st4, 5);
`ifdef FIFO_AXIS_DRAIN_STATS_EN
    chk("s6_pkt_cnt", pkt4, 3);
    chk("s6_stall_cnt", stall4, 5);
    chk("s6_pkt_cnt_idle16", pkt_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
